// File: rtl/axi_fifo_lvl.sv
// axi_fifo_lvl: valid/ready FIFO with occupancy count, almost-full/empty
// flags, synchronous flush and peak-occupancy tracking.
// Optional macro AXI_FIFO_LVL_OUTREG_EN adds a registered output stage
// after the RAM (capacity DEPTH+1, two-cycle empty-to-valid latency).
module axi_fifo_lvl #(
  parameter int WIDTH     = 64,
  parameter int MIN_DEPTH = 16,
  parameter int AF_LEVEL  = ((1 << $clog2(MIN_DEPTH)) < 2 ? 2 : (1 << $clog2(MIN_DEPTH))) - 2,
  parameter int AE_LEVEL  = 1,
  localparam int DEPTH    = ((1 << $clog2(MIN_DEPTH)) < 2) ? 2 : (1 << $clog2(MIN_DEPTH)),
`ifdef AXI_FIFO_LVL_OUTREG_EN
  localparam int CAP      = DEPTH + 1,
`else
  localparam int CAP      = DEPTH,
`endif
  localparam int CW       = $clog2(CAP) + 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             vld_in,
  input  logic [WIDTH-1:0] data_in,
  output logic             rdy_in,
  output logic             vld_out,
  output logic [WIDTH-1:0] data_out,
  input  logic             rdy_out,
  output logic [CW-1:0]    count,
  output logic             almost_full,
  output logic             almost_empty,
  output logic [CW-1:0]    max_count
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [CW-1:0] CAP_C = CW'(CAP);
  localparam logic [CW-1:0] AF_C  = CW'(AF_LEVEL);
  localparam logic [CW-1:0] AE_C  = CW'(AE_LEVEL);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             push;
  logic             pop;
  logic [CW-1:0]    count_next;

  assign push = vld_in & rdy_in;
  assign pop  = vld_out & rdy_out;

  assign almost_full  = (count >= AF_C);
  assign almost_empty = (count <= AE_C);

  // Next occupancy: push and pop in the same cycle cancel out.
  always_comb begin
    count_next = count + CW'(push) - CW'(pop);
  end

  // RAM write port; storage is not reset, validity is tracked by count.
  always_ff @(posedge clk) begin
    if (push && !flush) begin
      mem[wr_ptr] <= data_in;
    end
  end

  // Write pointer, occupancy, peak tracking and registered upstream ready.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr    <= '0;
      count     <= '0;
      max_count <= '0;
      rdy_in    <= 1'b0;
    end else if (flush) begin
      wr_ptr    <= '0;
      count     <= '0;
      max_count <= '0;
      rdy_in    <= 1'b0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + AW'(1);
      end
      count     <= count_next;
      max_count <= (count > max_count) ? count : max_count;
      rdy_in    <= (count_next < CAP_C);
    end
  end

`ifdef AXI_FIFO_LVL_OUTREG_EN
  logic [CW-1:0] ram_cnt;
  logic          load;

  // The output-register word is part of count but no longer in the RAM.
  assign ram_cnt = count - CW'(vld_out);
  assign load    = (ram_cnt != '0) && (!vld_out || rdy_out);

  // Output register refilled from the RAM head whenever it is empty or popped.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_ptr   <= '0;
      vld_out  <= 1'b0;
      data_out <= '0;
    end else if (flush) begin
      rd_ptr   <= '0;
      vld_out  <= 1'b0;
    end else if (load) begin
      data_out <= mem[rd_ptr];
      rd_ptr   <= rd_ptr + AW'(1);
      vld_out  <= 1'b1;
    end else if (pop) begin
      vld_out  <= 1'b0;
    end
  end
`else
  // Read pointer advances on each accepted output word.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_ptr <= '0;
    end else if (flush) begin
      rd_ptr <= '0;
    end else if (pop) begin
      rd_ptr <= rd_ptr + AW'(1);
    end
  end

  // First-word fall-through: head word read straight from the RAM.
  assign vld_out  = (count != '0);
  assign data_out = vld_out ? mem[rd_ptr] : '0;
`endif

endmodule
